// File: rtl/inst_mem_responder_if.sv
// Fetch/load bus between the CPU fetch path (master) and the instruction memory responder (slave).
// One interface instance carries the fetch request, the fetch response and the preload port.
interface inst_mem_responder_if;
    logic [31:0] instruction_address;
    logic        stall;
    logic [31:0] instruction_read_data;
    logic        instruction_valid;
    logic        instruction_fault;
    logic        load_en;
    logic [31:0] load_addr;
    logic [31:0] load_data;
    logic        load_err;

    modport master (
        output instruction_address, stall, load_en, load_addr, load_data,
        input  instruction_read_data, instruction_valid, instruction_fault, load_err
    );

    modport slave (
        input  instruction_address, stall, load_en, load_addr, load_data,
        output instruction_read_data, instruction_valid, instruction_fault, load_err
    );
endinterface

// File: rtl/inst_mem_responder.sv
// Instruction memory with a fixed-latency, stallable fetch pipeline and a write-only preload port.
// Stage 1 holds the memory read result; later stages only delay it by one edge each.
module inst_mem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 1,
    parameter logic [31:0] NOP_WORD    = 32'h0000_0013
) (
    input logic                  clk,
    input logic                  rst,
    inst_mem_responder_if.slave  bus
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef struct packed {
        logic [31:0] data;
        logic        fault;
    } resp_t;

    // Aligned and below DEPTH_WORDS*4: any set bit above the index field means out of range,
    // so high addresses can never wrap onto low memory.
    function automatic logic addr_ok(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a[31:AW+2] == '0);
    endfunction

    logic [31:0]          mem [DEPTH_WORDS];
    logic                 fetch_ok;
    logic                 load_ok;
    resp_t                s0;
    logic [LATENCY:1]     vld_pipe;
    resp_t [LATENCY:1]    pay_pipe;
    logic                 load_err_q;

    always_comb begin
        fetch_ok = addr_ok(bus.instruction_address);
        load_ok  = addr_ok(bus.load_addr);
        s0.data  = NOP_WORD;
        s0.fault = 1'b1;
        if (fetch_ok) begin
            s0.data  = mem[bus.instruction_address[AW+1:2]];
            s0.fault = 1'b0;
        end
    end

    // Non-blocking write against the stage-1 read above gives read-before-write on a collision.
    always_ff @(posedge clk) begin
        if (bus.load_en && load_ok)
            mem[bus.load_addr[AW+1:2]] <= bus.load_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            for (int i = 1; i <= LATENCY; i++)
                pay_pipe[i] <= '{data: NOP_WORD, fault: 1'b0};
        end else if (!bus.stall) begin
            vld_pipe[1] <= 1'b1;
            pay_pipe[1] <= s0;
            for (int i = 2; i <= LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                pay_pipe[i] <= pay_pipe[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) load_err_q <= 1'b0;
        else     load_err_q <= bus.load_en && !load_ok;
    end

    assign bus.instruction_read_data = pay_pipe[LATENCY].data;
    assign bus.instruction_fault     = pay_pipe[LATENCY].fault;
    assign bus.instruction_valid     = vld_pipe[LATENCY];
    assign bus.load_err              = load_err_q;

endmodule

// File: tb/tb_inst_mem_responder.sv
// Directed bench: four responders (LATENCY 1..4) share clock and reset; a vector table
// exercises the LATENCY=1 part, hand sequences cover stall, latency and mid-stream reset.
module tb_inst_mem_responder;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    inst_mem_responder_if ifc1 ();
    inst_mem_responder_if ifc2 ();
    inst_mem_responder_if ifc3 ();
    inst_mem_responder_if ifc4 ();

    inst_mem_responder #(.LATENCY(1)) u1 (.clk(clk), .rst(rst), .bus(ifc1.slave));
    inst_mem_responder #(.LATENCY(2)) u2 (.clk(clk), .rst(rst), .bus(ifc2.slave));
    inst_mem_responder #(.LATENCY(3)) u3 (.clk(clk), .rst(rst), .bus(ifc3.slave));
    inst_mem_responder #(.LATENCY(4)) u4 (.clk(clk), .rst(rst), .bus(ifc4.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        stall;
        logic        ld_en;
        logic [31:0] ld_addr;
        logic [31:0] ld_data;
        logic [31:0] exp_data;
        logic        exp_v;
        logic        exp_f;
        logic        exp_le;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic [31:0] addr, input logic stall, input logic ld_en,
                                input logic [31:0] ld_addr, input logic [31:0] ld_data,
                                input logic [31:0] exp_data, input logic exp_v,
                                input logic exp_f, input logic exp_le);
        vec_t r;
        r.addr = addr; r.stall = stall; r.ld_en = ld_en; r.ld_addr = ld_addr;
        r.ld_data = ld_data; r.exp_data = exp_data; r.exp_v = exp_v;
        r.exp_f = exp_f; r.exp_le = exp_le;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic [31:0] d, input logic v, input logic f,
                           input logic [31:0] ed, input logic ev, input logic ef);
        chk({name, ".data"},  d, ed);
        chk({name, ".valid"}, {31'd0, v}, {31'd0, ev});
        chk({name, ".fault"}, {31'd0, f}, {31'd0, ef});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        ifc1.instruction_address = '0; ifc1.stall = 1'b0; ifc1.load_en = 1'b0; ifc1.load_addr = '0; ifc1.load_data = '0;
        ifc2.instruction_address = '0; ifc2.stall = 1'b0; ifc2.load_en = 1'b0; ifc2.load_addr = '0; ifc2.load_data = '0;
        ifc3.instruction_address = '0; ifc3.stall = 1'b0; ifc3.load_en = 1'b0; ifc3.load_addr = '0; ifc3.load_data = '0;
        ifc4.instruction_address = '0; ifc4.stall = 1'b0; ifc4.load_en = 1'b0; ifc4.load_addr = '0; ifc4.load_data = '0;

        // Fault-address fetches while preloading keep every expected output known.
        vq.push_back(mk(32'h0000_0002, 0, 1, 32'h0000_0000, 32'hA0, 32'h13, 1, 1, 0));
        vq.push_back(mk(32'h0000_0002, 0, 1, 32'h0000_0004, 32'hA1, 32'h13, 1, 1, 0));
        vq.push_back(mk(32'h0000_1000, 0, 1, 32'h0000_0008, 32'hA2, 32'h13, 1, 1, 0));
        vq.push_back(mk(32'h0000_1000, 0, 1, 32'h0000_000C, 32'hA3, 32'h13, 1, 1, 0));
        vq.push_back(mk(32'h0000_0000, 0, 1, 32'h0000_0014, 32'h11, 32'hA0, 1, 0, 0));
        vq.push_back(mk(32'h0000_0004, 0, 1, 32'h0000_1002, 32'hDEAD, 32'hA1, 1, 0, 1));
        vq.push_back(mk(32'h0000_0008, 0, 0, 32'h0000_0000, 32'h0, 32'hA2, 1, 0, 0));
        vq.push_back(mk(32'h0000_000C, 0, 1, 32'h0000_0FFC, 32'h77, 32'hA3, 1, 0, 0));
        vq.push_back(mk(32'h0000_0FFC, 0, 0, 32'h0000_0000, 32'h0, 32'h77, 1, 0, 0));
        vq.push_back(mk(32'h0000_0014, 0, 1, 32'h0000_0014, 32'h22, 32'h11, 1, 0, 0));
        vq.push_back(mk(32'h0000_0014, 0, 0, 32'h0000_0000, 32'h0, 32'h22, 1, 0, 0));
        vq.push_back(mk(32'h0000_0000, 0, 0, 32'h0000_0000, 32'h0, 32'hA0, 1, 0, 0));
        vq.push_back(mk(32'h0000_4003, 0, 0, 32'h0000_0000, 32'h0, 32'h13, 1, 1, 0));
        vq.push_back(mk(32'hFFFF_FFFC, 0, 0, 32'h0000_0000, 32'h0, 32'h13, 1, 1, 0));
        vq.push_back(mk(32'h0000_0000, 0, 1, 32'h0000_0003, 32'h55, 32'hA0, 1, 0, 1));
        vq.push_back(mk(32'h0000_0008, 1, 0, 32'h0000_0000, 32'h0, 32'hA0, 1, 0, 0));
        vq.push_back(mk(32'h0000_0008, 0, 0, 32'h0000_0000, 32'h0, 32'hA2, 1, 0, 0));

        step();
        step();
        chk_out("rst_u1", ifc1.instruction_read_data, ifc1.instruction_valid, ifc1.instruction_fault, 32'h13, 0, 0);
        chk_out("rst_u4", ifc4.instruction_read_data, ifc4.instruction_valid, ifc4.instruction_fault, 32'h13, 0, 0);
        chk("rst_u1.load_err", {31'd0, ifc1.load_err}, 32'd0);
        rst = 1'b0;

        // Table: LATENCY=1 part checked; the others receive the same loads and fetch a fault address.
        foreach (vq[i]) begin
            ifc1.instruction_address = vq[i].addr;
            ifc1.stall     = vq[i].stall;
            ifc1.load_en   = vq[i].ld_en;
            ifc1.load_addr = vq[i].ld_addr;
            ifc1.load_data = vq[i].ld_data;
            ifc2.instruction_address = 32'h2; ifc2.load_en = vq[i].ld_en; ifc2.load_addr = vq[i].ld_addr; ifc2.load_data = vq[i].ld_data;
            ifc3.instruction_address = 32'h2; ifc3.load_en = vq[i].ld_en; ifc3.load_addr = vq[i].ld_addr; ifc3.load_data = vq[i].ld_data;
            ifc4.instruction_address = 32'h2; ifc4.load_en = vq[i].ld_en; ifc4.load_addr = vq[i].ld_addr; ifc4.load_data = vq[i].ld_data;
            step();
            chk_out($sformatf("vec%0d", i), ifc1.instruction_read_data, ifc1.instruction_valid,
                    ifc1.instruction_fault, vq[i].exp_data, vq[i].exp_v, vq[i].exp_f);
            chk($sformatf("vec%0d.load_err", i), {31'd0, ifc1.load_err}, {31'd0, vq[i].exp_le});
        end
        ifc1.load_en = 1'b0; ifc2.load_en = 1'b0; ifc3.load_en = 1'b0; ifc4.load_en = 1'b0;

        // Stall on LATENCY=2: stream 0,4 then freeze 3 cycles, then 8.
        ifc2.instruction_address = 32'h0;
        step();
        chk_out("stl_e1", ifc2.instruction_read_data, ifc2.instruction_valid, ifc2.instruction_fault, 32'h13, 1, 1);
        ifc2.instruction_address = 32'h4;
        step();
        chk_out("stl_e2", ifc2.instruction_read_data, ifc2.instruction_valid, ifc2.instruction_fault, 32'hA0, 1, 0);
        ifc2.instruction_address = 32'h8;
        ifc2.stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk_out($sformatf("stl_hold%0d", k), ifc2.instruction_read_data, ifc2.instruction_valid,
                    ifc2.instruction_fault, 32'hA0, 1, 0);
        end
        ifc2.stall = 1'b0;
        step();
        chk_out("stl_a1", ifc2.instruction_read_data, ifc2.instruction_valid, ifc2.instruction_fault, 32'hA1, 1, 0);
        ifc2.instruction_address = 32'h2;
        step();
        chk_out("stl_a2", ifc2.instruction_read_data, ifc2.instruction_valid, ifc2.instruction_fault, 32'hA2, 1, 0);
        step();
        chk_out("stl_after", ifc2.instruction_read_data, ifc2.instruction_valid, ifc2.instruction_fault, 32'h13, 1, 1);

        // Three fetches in flight on LATENCY=4, then reset.
        ifc4.instruction_address = 32'h0; step();
        ifc4.instruction_address = 32'h4; step();
        ifc4.instruction_address = 32'h8; step();
        chk_out("inflight_u4", ifc4.instruction_read_data, ifc4.instruction_valid, ifc4.instruction_fault, 32'h13, 1, 1);
        rst = 1'b1;
        #1;
        chk_out("async_rst_u4", ifc4.instruction_read_data, ifc4.instruction_valid, ifc4.instruction_fault, 32'h13, 0, 0);
        chk("async_rst_u3.valid", {31'd0, ifc3.instruction_valid}, 32'd0);
        ifc3.instruction_address = 32'h4;
        ifc4.instruction_address = 32'hC;
        step();
        step();
        chk("in_rst_u4.valid", {31'd0, ifc4.instruction_valid}, 32'd0);
        rst = 1'b0;

        step();  // E1
        chk("e1_u3.valid", {31'd0, ifc3.instruction_valid}, 32'd0);
        chk("e1_u4.valid", {31'd0, ifc4.instruction_valid}, 32'd0);
        ifc3.instruction_address = 32'h0;
        step();  // E2
        chk("e2_u3.valid", {31'd0, ifc3.instruction_valid}, 32'd0);
        chk("e2_u4.valid", {31'd0, ifc4.instruction_valid}, 32'd0);
        step();  // E3
        chk_out("lat3_first", ifc3.instruction_read_data, ifc3.instruction_valid, ifc3.instruction_fault, 32'hA1, 1, 0);
        chk("e3_u4.valid", {31'd0, ifc4.instruction_valid}, 32'd0);
        step();  // E4
        chk_out("lat3_second", ifc3.instruction_read_data, ifc3.instruction_valid, ifc3.instruction_fault, 32'hA0, 1, 0);
        chk_out("u4_post_rst", ifc4.instruction_read_data, ifc4.instruction_valid, ifc4.instruction_fault, 32'hA3, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
